// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl. The pipeline is the master: it drives the
// ID/EX and IF/ID fields and the branch and memory status. hazard_ctrl is the slave: it
// returns the write enables, flush, bubble and stall controls.
interface hazard_ctrl_if;
  logic       IDEX_MemRead_i;
  logic [4:0] IDEX_RTaddr_i;
  logic [4:0] IFID_RSaddr_i;
  logic [4:0] IFID_RTaddr_i;
  logic       Branch_i;
  logic       Jump_i;
  logic       MemBusy_i;
  logic       PCWrite_o;
  logic       IFIDWrite_o;
  logic       IFIDFlush_o;
  logic       CtrlZero_o;
  logic       Stall_o;
  logic       Err_o;

  modport master (
    output IDEX_MemRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i,
    output Branch_i, Jump_i, MemBusy_i,
    input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, CtrlZero_o, Stall_o, Err_o
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i,
    input  Branch_i, Jump_i, MemBusy_i,
    output PCWrite_o, IFIDWrite_o, IFIDFlush_o, CtrlZero_o, Stall_o, Err_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use bubbles, branch/jump flushes, multi-cycle
// data-memory waits with a timeout watchdog, and a pending-flush latch so a branch seen
// while the pipe is frozen is not lost.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned MEM_TIMEOUT = 200
) (
  input  logic            clk_i,
  input  logic            rst_i,
  hazard_ctrl_if.slave    bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     LoadStallCnt_o,
  output logic [31:0]     MemStallCnt_o,
  output logic [31:0]     FlushCnt_o
`endif
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMemWait = 2'd1;
  localparam logic [1:0] StError   = 2'd2;

  localparam logic [TIMEOUT_W-1:0] TimeoutVal = TIMEOUT_W'(MEM_TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] CntMax     = '1;

  logic [1:0]           state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 flush_pend_q, flush_pend_d;

  logic load_use;
  logic redirect;
  logic pc_write, ifid_write, ifid_flush, ctrl_zero, stall, err;
  logic load_stall;

  assign load_use = bus.IDEX_MemRead_i && (bus.IDEX_RTaddr_i != 5'd0) &&
                    ((bus.IDEX_RTaddr_i == bus.IFID_RSaddr_i) ||
                     (bus.IDEX_RTaddr_i == bus.IFID_RTaddr_i));
  assign redirect = bus.Branch_i || bus.Jump_i;

  // Next-state and output decode; reset forces the safe output pattern last.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    ctrl_zero    = 1'b0;
    stall        = 1'b0;
    err          = 1'b0;
    load_stall   = 1'b0;

    case (state_q)
      StRun, StMemWait: begin
        if (state_q == StMemWait && bus.MemBusy_i) begin
          stall = 1'b1;
          if (redirect) flush_pend_d = 1'b1;
          if (cnt_q == TimeoutVal) state_d = StError;
          if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
        end else begin
          // The cycle MemBusy drops is already a normal RUN cycle: hazards are evaluated
          // combinationally so no extra dead cycle follows a memory wait.
          state_d = StRun;
          if (state_q == StMemWait) cnt_d = '0;
          if (bus.MemBusy_i) begin
            stall   = 1'b1;
            cnt_d   = TIMEOUT_W'(1);
            state_d = StMemWait;
            if (redirect) flush_pend_d = 1'b1;
          end else if (load_use) begin
            // ID re-evaluates the branch next cycle, so it is deliberately not latched.
            ctrl_zero  = 1'b1;
            load_stall = 1'b1;
          end else if (redirect || flush_pend_q) begin
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            ifid_flush   = 1'b1;
            flush_pend_d = 1'b0;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
      end
      StError: begin
        stall     = 1'b1;
        ctrl_zero = 1'b1;
        err       = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (rst_i) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      ctrl_zero  = 1'b1;
      stall      = 1'b0;
      err        = 1'b0;
      load_stall = 1'b0;
    end
  end

  // State, watchdog counter and pending-flush latch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StRun;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.PCWrite_o   = pc_write;
  assign bus.IFIDWrite_o = ifid_write;
  assign bus.IFIDFlush_o = ifid_flush;
  assign bus.CtrlZero_o  = ctrl_zero;
  assign bus.Stall_o     = stall;
  assign bus.Err_o       = err;

`ifdef HAZARD_STATS_EN
  logic [31:0] load_cnt_q, mem_cnt_q, flush_cnt_q;
  logic        mem_stall_evt;

  // A memory stall is any frozen cycle outside ERROR; reset already forces stall low.
  assign mem_stall_evt = stall && (state_q != StError);

  // Saturating event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_cnt_q  <= '0;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_stall && load_cnt_q != 32'hFFFF_FFFF) load_cnt_q <= load_cnt_q + 32'd1;
      if (mem_stall_evt && mem_cnt_q != 32'hFFFF_FFFF) mem_cnt_q <= mem_cnt_q + 32'd1;
      if (ifid_flush && flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign LoadStallCnt_o = load_cnt_q;
  assign MemStallCnt_o  = mem_cnt_q;
  assign FlushCnt_o     = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Each driven cycle pushes its expected output vector
// {PCWrite, IFIDWrite, IFIDFlush, CtrlZero, Stall, Err} onto a scoreboard; a monitor pops
// and compares on the falling edge. Stats counters are checked when HAZARD_STATS_EN is set.
module tb_hazard_ctrl;
  localparam int unsigned MemTimeout = 200;

  localparam logic [5:0] ExpRst   = 6'b001100;
  localparam logic [5:0] ExpRun   = 6'b110000;
  localparam logic [5:0] ExpLu    = 6'b000100;
  localparam logic [5:0] ExpFlush = 6'b111000;
  localparam logic [5:0] ExpMem   = 6'b000010;
  localparam logic [5:0] ExpErr   = 6'b000111;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } sb_item_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  sb_item_t sb[$];

  hazard_ctrl_if bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] load_cnt, mem_cnt, flush_cnt;
`endif

  hazard_ctrl #(
    .TIMEOUT_W  (8),
    .MEM_TIMEOUT(MemTimeout)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus.slave)
`ifdef HAZARD_STATS_EN
    ,
    .LoadStallCnt_o(load_cnt),
    .MemStallCnt_o (mem_cnt),
    .FlushCnt_o    (flush_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs it must produce.
  task automatic step(input logic rst, input logic mr, input logic [4:0] ld_rt,
                      input logic [4:0] rs, input logic [4:0] rt, input logic br,
                      input logic jmp, input logic busy, input logic [5:0] exp,
                      input string tag);
    sb_item_t it;
    @(posedge clk_i);
    #1;
    rst_i              = rst;
    bus.IDEX_MemRead_i = mr;
    bus.IDEX_RTaddr_i  = ld_rt;
    bus.IFID_RSaddr_i  = rs;
    bus.IFID_RTaddr_i  = rt;
    bus.Branch_i       = br;
    bus.Jump_i         = jmp;
    bus.MemBusy_i      = busy;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic idle(input logic [5:0] exp, input string tag);
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, exp, tag);
  endtask

  // Scoreboard monitor: outputs are combinational, so compare mid-cycle.
  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      sb_item_t it;
      logic [5:0] got;
      it  = sb.pop_front();
      got = {bus.PCWrite_o, bus.IFIDWrite_o, bus.IFIDFlush_o, bus.CtrlZero_o,
             bus.Stall_o, bus.Err_o};
      check(it.tag, 32'(got), 32'(it.exp));
    end
  end

  initial begin
    bus.IDEX_MemRead_i = 1'b0;
    bus.IDEX_RTaddr_i  = '0;
    bus.IFID_RSaddr_i  = '0;
    bus.IFID_RTaddr_i  = '0;
    bus.Branch_i       = 1'b0;
    bus.Jump_i         = 1'b0;
    bus.MemBusy_i      = 1'b0;

    // Reset for two cycles, then plain running.
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ExpRst, "reset0");
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ExpRst, "reset1");
    idle(ExpRun, "run_after_reset");

    // Load-use on RS, on RT, on both, and against $0.
    step(1'b0, 1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, ExpLu, "lu_rs");
    idle(ExpRun, "lu_rs_after");
    step(1'b0, 1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, ExpLu, "lu_rt");
    step(1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, ExpLu, "lu_both");
    idle(ExpRun, "lu_both_after");
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ExpRun, "lu_zero");
    step(1'b0, 1'b1, 5'd4, 5'd3, 5'd6, 1'b0, 1'b0, 1'b0, ExpRun, "lu_nomatch");
    step(1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, ExpRun, "no_memread");

    // Hazard masks the branch; the branch re-presented alone flushes once.
    step(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, ExpLu, "lu_branch");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, ExpFlush, "branch_flush");
    idle(ExpRun, "branch_after");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, ExpFlush, "jump_flush");

    // Four busy cycles with a jump in the second: flush lands when memory frees.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ExpMem, "mw1");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, ExpMem, "mw2");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ExpMem, "mw3");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ExpMem, "mw4");
    idle(ExpFlush, "mw_pend_flush");
    idle(ExpRun, "mw_pend_cleared");

    // Branch on the first busy cycle (from RUN) is latched too.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, ExpMem, "mw_br_run");
    idle(ExpFlush, "mw_br_flush");

    // Pending flush held back by a load-use in the release cycle, applied next cycle.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, ExpMem, "pend_busy");
    step(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, ExpLu, "pend_lu");
    idle(ExpFlush, "pend_after_lu");
    idle(ExpRun, "pend_done");

    // Reset mid-wait drops the pending flush.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, ExpMem, "mid_busy");
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ExpRst, "mid_reset");
    idle(ExpRun, "mid_reset_clean");

    // Watchdog: MEM_TIMEOUT+2 busy cycles ends in ERROR.
    for (int i = 1; i <= int'(MemTimeout) + 2; i++) begin
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1,
           (i <= int'(MemTimeout) + 1) ? ExpMem : ExpErr, $sformatf("tmo_%0d", i));
    end
    idle(ExpErr, "err_sticky0");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, ExpErr, "err_sticky1");
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ExpRst, "err_reset");
    idle(ExpRun, "err_cleared");

`ifdef HAZARD_STATS_EN
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ExpRst, "st_reset");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, ExpLu, "st_lu");
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, ExpFlush, "st_br");
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ExpMem, "st_mem");
    end
    idle(ExpRun, "st_idle");
    @(negedge clk_i);
    check("load_stall_cnt", load_cnt, 32'd3);
    check("flush_cnt", flush_cnt, 32'd2);
    check("mem_stall_cnt", mem_cnt, 32'd5);
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk_i);
    @(posedge clk_i);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
